// File: rtl/rdest_wb_scoreboard.sv
// Writeback destination decoder with registered one-hot regEnable, per-register busy scoreboard
// and issue hazard generation. Define RDEST_WB_R0_ZERO_EN to make register 0 hardwired zero.
module rdest_wb_scoreboard #(
  parameter int unsigned REG_COUNT       = 16,
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rdest,
  input  logic [ADDR_W-1:0]    issue_src_a,
  input  logic [ADDR_W-1:0]    issue_src_b,
  output logic                 issue_accept,
  output logic                 hazard,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rdest,
  output logic [REG_COUNT-1:0] regEnable,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic [ADDR_W:0]      outstanding,
  output logic                 wb_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef RDEST_WB_R0_ZERO_EN
  localparam logic [REG_COUNT-1:0] WRITABLE = ~REG_COUNT'(1);
`else
  localparam logic [REG_COUNT-1:0] WRITABLE = '1;
`endif
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // One-hot decode; an out-of-range index decodes to all zeros.
  function automatic logic [REG_COUNT-1:0] f_onehot(input logic [ADDR_W-1:0] idx);
    logic [REG_COUNT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (32'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [REG_COUNT-1:0] r_reg_enable;
  logic [REG_COUNT-1:0] r_busy;
  logic [CNT_W-1:0]     r_outstanding;
  logic                 r_wb_err;

  logic [REG_COUNT-1:0] w_wb_raw;
  logic [REG_COUNT-1:0] w_wb_dec;
  logic                 w_wb_hit;
  logic                 w_wb_fixed;
  logic                 w_wb_err_set;
  logic [REG_COUNT-1:0] w_eff_busy;
  logic [REG_COUNT-1:0] w_rd_dec;
  logic [REG_COUNT-1:0] w_src_dec;
  logic                 w_rd_ok;
  logic                 w_rd_tracked;
  logic                 w_dep_busy;
  logic [CNT_W-1:0]     w_cnt_base;
  logic                 w_full;
  logic                 w_hazard;
  logic                 w_accept;
  logic [REG_COUNT-1:0] w_set;
  logic                 w_inc;

  // Writeback decode and same-cycle bypass of the busy bit being retired.
  always_comb begin
    w_wb_raw     = f_onehot(wb_rdest);
    w_wb_dec     = w_wb_raw & WRITABLE & {REG_COUNT{wb_valid}};
    w_wb_hit     = |(r_busy & w_wb_dec);
    w_wb_fixed   = |(w_wb_raw & ~WRITABLE);
    w_wb_err_set = wb_valid && !w_wb_fixed && !w_wb_hit;
    w_eff_busy   = r_busy & ~w_wb_dec;
  end

  // Issue hazard: RAW on either source, WAW on destination, bad index, or no free slot.
  always_comb begin
    w_rd_dec     = f_onehot(issue_rdest);
    w_src_dec    = f_onehot(issue_src_a) | f_onehot(issue_src_b);
    w_rd_ok      = |w_rd_dec;
    w_rd_tracked = |(w_rd_dec & WRITABLE);
    w_dep_busy   = |(w_eff_busy & (w_src_dec | w_rd_dec));
    w_cnt_base   = r_outstanding - CNT_W'(w_wb_hit);
    w_full       = w_rd_tracked && (w_cnt_base >= MAX_CNT);
    w_hazard     = issue_valid && (w_dep_busy || !w_rd_ok || w_full);
    w_accept     = issue_valid && !w_hazard;
    w_set        = w_rd_dec & WRITABLE & {REG_COUNT{w_accept}};
    w_inc        = w_accept && w_rd_tracked;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_enable  <= '0;
      r_busy        <= '0;
      r_outstanding <= '0;
      r_wb_err      <= 1'b0;
    end else begin
      r_reg_enable  <= w_wb_dec;
      r_busy        <= w_eff_busy | w_set;
      r_outstanding <= w_cnt_base + CNT_W'(w_inc);
      if (w_wb_err_set) r_wb_err <= 1'b1;
    end
  end

  assign hazard       = w_hazard;
  assign issue_accept = w_accept;
  assign regEnable    = r_reg_enable;
  assign busy_mask    = r_busy;
  assign outstanding  = r_outstanding;
  assign wb_err       = r_wb_err;

`ifndef SYNTHESIS
  a_regen_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(regEnable));
  a_cnt_bound:    assert property (@(posedge clk) disable iff (reset) outstanding <= MAX_CNT);
  a_cnt_popcount: assert property (@(posedge clk) disable iff (reset)
                                   32'(outstanding) == 32'($countones(busy_mask)));
`endif

endmodule

// File: tb/tb_rdest_wb_scoreboard.sv
// Self-checking bench for rdest_wb_scoreboard: directed scenarios plus randomized traffic
// against a per-register busy-array reference model.
module tb_rdest_wb_scoreboard;

  localparam int RC   = 16;
  localparam int MAXO = 4;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_rdest, issue_src_a, issue_src_b;
  logic        issue_accept, hazard;
  logic        wb_valid;
  logic [3:0]  wb_rdest;
  logic [15:0] regEnable, busy_mask;
  logic [4:0]  outstanding;
  logic        wb_err;

  rdest_wb_scoreboard #(.REG_COUNT(16), .ADDR_W(4), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rdest(issue_rdest),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b),
    .issue_accept(issue_accept), .hazard(hazard),
    .wb_valid(wb_valid), .wb_rdest(wb_rdest),
    .regEnable(regEnable), .busy_mask(busy_mask),
    .outstanding(outstanding), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_busy [RC];
  int          m_cnt;
  bit          m_err;
  logic [15:0] m_regen;
  bit          exp_haz, exp_acc, obs_haz, obs_acc;

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < RC; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit m_is_busy(input int idx);
    return (idx < RC) ? m_busy[idx] : 1'b0;
  endfunction

  // Apply one cycle of inputs, record observed/expected hazard, advance the model at the edge.
  task automatic cyc(input bit rst, input bit iv, input int rd, input int a, input int b,
                     input bit wv, input int wr);
    bit eff [RC];
    bit wb_clear;
    int pending;
    reset = rst; issue_valid = iv;
    issue_rdest = 4'(rd); issue_src_a = 4'(a); issue_src_b = 4'(b);
    wb_valid = wv; wb_rdest = 4'(wr);
    #2;
    eff = m_busy;
    wb_clear = wv && (wr < RC) && m_busy[wr];
    if (wv && wr < RC) eff[wr] = 1'b0;
    pending = m_cnt - (wb_clear ? 1 : 0);
    exp_haz = iv && (((a < RC) && eff[a]) || ((b < RC) && eff[b]) ||
                     (rd >= RC) || ((rd < RC) && eff[rd]) || (pending == MAXO));
    exp_acc = iv && !exp_haz;
    obs_haz = hazard;
    obs_acc = issue_accept;
    @(posedge clk);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cnt = 0; m_err = 1'b0; m_regen = '0;
    end else begin
      m_regen = (wv && wr < RC) ? (16'h0001 << wr) : 16'h0000;
      if (wv && (wr >= RC || !m_busy[wr])) m_err = 1'b1;
      if (wb_clear) begin m_busy[wr] = 1'b0; m_cnt--; end
      if (exp_acc) begin m_busy[rd] = 1'b1; m_cnt++; end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle();
    n_vec++; if (regEnable !== 16'h0000) begin n_err++; $display("FAIL reset_regen got %h want 0000", regEnable); end
    n_vec++; if (busy_mask !== 16'h0000) begin n_err++; $display("FAIL reset_busy got %h want 0000", busy_mask); end
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_wb_err got %b want 0", wb_err); end
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard got %b want 0", hazard); end
  endtask

  // Issue register k while retiring k-1 in the same cycle.
  task automatic test_decode_sweep();
    logic [15:0] want;
    for (int k = 0; k <= RC; k++) begin
      cyc(0, k < RC, k, 0, 0, k > 0, k - 1);
      n_vec++;
      if (obs_acc !== exp_acc) begin n_err++; $display("FAIL sweep_accept k=%0d got %b want %b", k, obs_acc, exp_acc); end
      if (k > 0) begin
        want = 16'h0001 << (k - 1);
        n_vec++;
        if (regEnable !== want || regEnable !== m_regen) begin
          n_err++; $display("FAIL sweep_regen idx=%0d got %h want %h", k - 1, regEnable, want);
        end
      end
    end
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL sweep_outstanding got %0d want 0", outstanding); end
  endtask

  task automatic test_raw_bypass();
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(0, 1, 7, 5, 0, 0, 0);
    n_vec++; if (obs_haz !== 1'b1 || obs_acc !== 1'b0) begin n_err++; $display("FAIL raw_stall got haz=%b acc=%b want haz=1 acc=0", obs_haz, obs_acc); end
    cyc(0, 1, 7, 5, 0, 1, 5);
    n_vec++; if (obs_haz !== 1'b0 || obs_acc !== 1'b1) begin n_err++; $display("FAIL raw_bypass got haz=%b acc=%b want haz=0 acc=1", obs_haz, obs_acc); end
    n_vec++; if (busy_mask !== 16'h0080) begin n_err++; $display("FAIL raw_busy got %h want 0080", busy_mask); end
    cyc(0, 0, 0, 0, 0, 1, 7);
  endtask

  task automatic test_same_reg();
    cyc(0, 1, 3, 0, 0, 0, 0);
    n_vec++; if (busy_mask !== 16'h0008) begin n_err++; $display("FAIL same_pre_busy got %h want 0008", busy_mask); end
    cyc(0, 1, 3, 0, 1, 1, 3);
    n_vec++; if (obs_haz !== 1'b0) begin n_err++; $display("FAIL same_hazard got %b want 0", obs_haz); end
    n_vec++; if (busy_mask !== 16'h0008) begin n_err++; $display("FAIL same_busy got %h want 0008", busy_mask); end
    n_vec++; if (outstanding !== 5'd1) begin n_err++; $display("FAIL same_outstanding got %0d want 1", outstanding); end
    n_vec++; if (regEnable !== 16'h0008) begin n_err++; $display("FAIL same_regen got %h want 0008", regEnable); end
    cyc(0, 0, 0, 0, 0, 1, 3);
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) cyc(0, 1, r, 0, 0, 0, 0);
    cyc(0, 1, 9, 0, 0, 0, 0);
    n_vec++; if (obs_haz !== 1'b1) begin n_err++; $display("FAIL cap_hazard got %b want 1", obs_haz); end
    n_vec++; if (outstanding !== 5'd4) begin n_err++; $display("FAIL cap_outstanding got %0d want 4", outstanding); end
    cyc(0, 1, 9, 0, 0, 1, 2);
    n_vec++; if (obs_acc !== 1'b1) begin n_err++; $display("FAIL cap_accept got %b want 1", obs_acc); end
    n_vec++; if (busy_mask !== 16'h021A) begin n_err++; $display("FAIL cap_busy got %h want 021a", busy_mask); end
    foreach (m_busy[i]) if (m_busy[i]) cyc(0, 0, 0, 0, 0, 1, i);
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL cap_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_error_reset();
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 6);
    n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", wb_err); end
    n_vec++; if (regEnable !== 16'h0040) begin n_err++; $display("FAIL err_regen got %h want 0040", regEnable); end
    idle();
    n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", wb_err); end
    cyc(1, 1, 2, 0, 0, 1, 5);
    n_vec++;
    if (busy_mask !== 16'h0000 || outstanding !== 5'd0 || wb_err !== 1'b0 || regEnable !== 16'h0000) begin
      n_err++; $display("FAIL err_reset got busy=%h out=%0d err=%b regen=%h want all 0",
                        busy_mask, outstanding, wb_err, regEnable);
    end
  endtask

  task automatic test_random();
    int busy_q [$];
    bit rst, iv, wv;
    int rd, a, b, wr;
    for (int n = 0; n < 400; n++) begin
      busy_q.delete();
      foreach (m_busy[i]) if (m_busy[i]) busy_q.push_back(i);
      rst = ($urandom_range(0, 59) == 0);
      iv  = $urandom_range(0, 1);
      rd  = $urandom_range(0, RC - 1);
      a   = $urandom_range(0, RC - 1);
      b   = $urandom_range(0, RC - 1);
      wv = 1'b0; wr = 0;
      if (busy_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wv = 1'b1; wr = busy_q[$urandom_range(0, busy_q.size() - 1)];
      end else if ($urandom_range(0, 24) == 0) begin
        wv = 1'b1; wr = $urandom_range(0, RC - 1);
      end
      cyc(rst, iv, rd, a, b, wv, wr);
      n_vec++; if (obs_haz !== exp_haz) begin n_err++; $display("FAIL rnd_hazard n=%0d got %b want %b", n, obs_haz, exp_haz); end
      n_vec++; if (obs_acc !== exp_acc) begin n_err++; $display("FAIL rnd_accept n=%0d got %b want %b", n, obs_acc, exp_acc); end
      n_vec++; if (regEnable !== m_regen) begin n_err++; $display("FAIL rnd_regen n=%0d got %h want %h", n, regEnable, m_regen); end
      n_vec++; if (busy_mask !== m_busy_vec()) begin n_err++; $display("FAIL rnd_busy n=%0d got %h want %h", n, busy_mask, m_busy_vec()); end
      n_vec++; if (outstanding !== 5'(m_cnt)) begin n_err++; $display("FAIL rnd_outstanding n=%0d got %0d want %0d", n, outstanding, m_cnt); end
      n_vec++; if (wb_err !== m_err) begin n_err++; $display("FAIL rnd_wb_err n=%0d got %b want %b", n, wb_err, m_err); end
    end
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt = 0; m_err = 1'b0; m_regen = '0;
    reset = 1'b1; issue_valid = 1'b0; issue_rdest = '0; issue_src_a = '0; issue_src_b = '0;
    wb_valid = 1'b0; wb_rdest = '0;
    test_reset();
    test_decode_sweep();
    test_raw_bypass();
    test_same_reg();
    test_capacity();
    test_error_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rdest_wb_scoreboard.md
Name: rdest_wb_scoreboard

Overview:
- Parametrised successor to the combinational Rdest-to-regEnable decoder in the CPU datapath.
- Decodes the writeback destination index into a registered one-hot register-file write enable.
- Tracks per-register busy bits for in-flight multi-cycle writers (loads, multi-cycle ALU ops) and produces a hazard/stall signal for the issue stage.
- Sits between the decode/issue stage and the register-file write port.

Parameters:
- REG_COUNT, 16, number of architectural registers; width of regEnable and busy_mask.
- ADDR_W, 4, width of register index fields; requires 2^ADDR_W >= REG_COUNT.
- MAX_OUTSTANDING, 4, maximum simultaneously busy registers; range 1..REG_COUNT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  issue stage presents an instruction that writes issue_rdest.
- issue_rdest  input  ADDR_W  destination register of the issuing instruction.
- issue_src_a  input  ADDR_W  first source register of the issuing instruction.
- issue_src_b  input  ADDR_W  second source register of the issuing instruction.
- issue_accept  output  1  issue accepted this cycle; equals issue_valid && !hazard.
- hazard  output  1  combinational stall request to the issue stage.
- wb_valid  input  1  a writer completes and writes wb_rdest this cycle.
- wb_rdest  input  ADDR_W  writeback destination index.
- regEnable  output  REG_COUNT  registered one-hot register-file write enable.
- busy_mask  output  REG_COUNT  registered busy bit per register.
- outstanding  output  ADDR_W+1  count of set busy bits.
- wb_err  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, clk edge with reset=1): regEnable=0, busy_mask=0, outstanding=0, wb_err=0. Reset overrides all same-cycle issue/wb activity and clears in-flight state mid-operation.
- Index validity: an index >= REG_COUNT is out of range. It never sets a busy bit and never produces regEnable.
  - issue_rdest out of range with issue_valid=1 forces hazard=1.
  - wb_rdest out of range with wb_valid=1 sets wb_err.
- regEnable:
  - At clk edge with wb_valid=1 and wb_rdest in range, regEnable = one-hot(wb_rdest) for exactly one cycle. Otherwise regEnable = 0 the next cycle.
  - Latency: 1 cycle from wb_valid to regEnable.
  - At most one bit set at any time.
- Effective busy (combinational): eff_busy = busy_mask with bit wb_rdest cleared when wb_valid=1. This is the same-cycle writeback bypass.
- hazard = issue_valid && (any of the following):
  - eff_busy[issue_src_a]
  - eff_busy[issue_src_b]
  - eff_busy[issue_rdest] (WAW)
  - issue_rdest out of range
  - outstanding_next_without_issue == MAX_OUTSTANDING
- hazard = 0 whenever issue_valid = 0.
- Busy update at clk edge:
  - If wb_valid and wb_rdest in range, clear bit wb_rdest.
  - Then, if issue_accept, set bit issue_rdest.
  - Same register cleared and set in one cycle: the bit ends at 1.
- outstanding:
  - +1 on accept only.
  - -1 on valid clearing writeback only, i.e. wb to a register that was busy.
  - Unchanged when both occur, or when neither occurs.
  - Never exceeds MAX_OUTSTANDING; never wraps below 0.
- wb_err:
  - Set at clk edge on wb_valid with an out-of-range index, or with busy_mask[wb_rdest]=0 (unexpected writeback).
  - An unexpected in-range writeback still drives regEnable, so the register file is written.
  - Cleared only by reset.

Optional Feature:
- Macro: RDEST_WB_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero.
  - regEnable[0] is never asserted.
  - busy_mask[0] stays 0.
  - Issue with rdest=0 is accepted without setting any busy bit and without changing outstanding.
  - Sources equal to 0 never cause a hazard.
  - wb_rdest=0 produces no enable and no wb_err.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then all inputs 0. Required: regEnable=0, busy_mask=0, outstanding=0, hazard=0, wb_err=0.
- Decode sweep: wb_valid=1 with wb_rdest 0..15 on consecutive cycles after issuing each register. Required: one cycle later regEnable=16'h0001, 16'h0002, ... 16'h8000, and outstanding drops to 0.
- RAW stall and bypass:
  - Issue rdest=5. Next cycle issue src_a=5, rdest=7 → hazard=1, issue_accept=0.
  - Same cycle wb_valid=1, wb_rdest=5 → hazard=0, accept=1, busy_mask=16'h0080.
- Same-register clear/set: busy_mask=16'h0008, issue rdest=3 with sources 0,1 while wb_rdest=3. Required: hazard=0, busy_mask stays 16'h0008, outstanding unchanged, regEnable=16'h0008 next cycle.
- Capacity: MAX_OUTSTANDING=4. Issue rdest 1,2,3,4, then issue rdest=9. Required: hazard=1, outstanding=4. After wb to 2, issue rdest=9 is accepted and busy_mask=16'h021A.
- Error and reset: wb_rdest=6 with busy_mask[6]=0. Required: wb_err=1 and regEnable=16'h0040. Then reset asserted with issue_valid=1 in the same cycle: all state returns to 0 and no busy bit is set.
